alu_issue_stage: RTL

//  Decode/issue stage that produces the operation stream the ALU consumes. It also produces the ALU operands.

---
 rtl/alu_issue_stage_pkg.sv | 72 +++++++
 rtl/alu_issue_stage_if.sv | 32 +++
 rtl/alu_issue_stage_decode.sv | 98 +++++++++
 rtl/alu_issue_stage.sv | 105 ++++++++++
 4 files changed

// File: rtl/alu_issue_stage_pkg.sv
// Shared constants for the ALU issue stage: ALU opcode and RV32I field defines, payload type.
// Also provides the funct3 -> ALU opcode helper used by the decoder.
`ifndef ALU_ISSUE_STAGE_DEFS
`define ALU_ISSUE_STAGE_DEFS
`define ADD  6'd0
`define SUB  6'd1
`define SLL  6'd2
`define SLT  6'd3
`define SLTU 6'd4
`define XOR  6'd5
`define SRL  6'd6
`define SRA  6'd7
`define OR   6'd8
`define AND  6'd9
`define OPC_OP     7'b0110011
`define OPC_OP_IMM 7'b0010011
`define OPC_LUI    7'b0110111
`define OPC_AUIPC  7'b0010111
`define F7_BASE    7'b0000000
`define F7_ALT     7'b0100000
`define F3_ADD_SUB 3'b000
`define F3_SLL     3'b001
`define F3_SLT     3'b010
`define F3_SLTU    3'b011
`define F3_XOR     3'b100
`define F3_SRL_SRA 3'b101
`define F3_OR      3'b110
`define F3_AND     3'b111
`endif

package alu_issue_stage_pkg;

    localparam int unsigned XLEN = 32;
    localparam int unsigned OP_W = 6;

    localparam logic [OP_W-1:0] ALU_ADD  = `ADD;
    localparam logic [OP_W-1:0] ALU_SUB  = `SUB;
    localparam logic [OP_W-1:0] ALU_SLL  = `SLL;
    localparam logic [OP_W-1:0] ALU_SLT  = `SLT;
    localparam logic [OP_W-1:0] ALU_SLTU = `SLTU;
    localparam logic [OP_W-1:0] ALU_XOR  = `XOR;
    localparam logic [OP_W-1:0] ALU_SRL  = `SRL;
    localparam logic [OP_W-1:0] ALU_SRA  = `SRA;
    localparam logic [OP_W-1:0] ALU_OR   = `OR;
    localparam logic [OP_W-1:0] ALU_AND  = `AND;

    typedef struct packed {
        logic [OP_W-1:0] alu_op;
        logic [XLEN-1:0] a;
        logic [XLEN-1:0] b;
        logic [4:0]      rd;
        logic            rd_we;
        logic            illegal;
    } issue_t;

    // Base (funct7=0) mapping shared by OP and OP-IMM.
    function automatic logic [OP_W-1:0] f3_to_op(input logic [2:0] f3);
        logic [OP_W-1:0] op;
        case (f3)
            `F3_ADD_SUB: op = ALU_ADD;
            `F3_SLL:     op = ALU_SLL;
            `F3_SLT:     op = ALU_SLT;
            `F3_SLTU:    op = ALU_SLTU;
            `F3_XOR:     op = ALU_XOR;
            `F3_SRL_SRA: op = ALU_SRL;
            `F3_OR:      op = ALU_OR;
            default:     op = ALU_AND;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/alu_issue_stage_if.sv
// Upstream/downstream handshake bundle for alu_issue_stage.
// master = fetch/ALU environment side, slave = the issue stage.
interface alu_issue_stage_if;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_instr;
    logic [31:0] in_pc;
    logic [4:0]  rs1_addr;
    logic [4:0]  rs2_addr;
    logic [31:0] rs1_data;
    logic [31:0] rs2_data;
    logic        out_valid;
    logic        out_ready;
    logic [5:0]  out_alu_op;
    logic [31:0] out_a;
    logic [31:0] out_b;
    logic [4:0]  out_rd;
    logic        out_rd_we;
    logic        out_illegal;

    modport master (
        output in_valid, in_instr, in_pc, rs1_data, rs2_data, out_ready,
        input  in_ready, rs1_addr, rs2_addr, out_valid, out_alu_op, out_a, out_b, out_rd,
               out_rd_we, out_illegal
    );

    modport slave (
        input  in_valid, in_instr, in_pc, rs1_data, rs2_data, out_ready,
        output in_ready, rs1_addr, rs2_addr, out_valid, out_alu_op, out_a, out_b, out_rd,
               out_rd_we, out_illegal
    );
endinterface

// File: rtl/alu_issue_stage_decode.sv
// rv32i_alu_decode: combinational RV32I OP/OP-IMM/LUI/AUIPC decode into an ALU issue payload.
// DECODE_ILLEGAL_TRAP_EN: illegal entries are normalised to ADD 0,0 so they can issue as traps.
module rv32i_alu_decode
    import alu_issue_stage_pkg::*;
(
    input  logic [31:0] i_instr,
    input  logic [31:0] i_pc,
    input  logic [31:0] i_rs1_data,
    input  logic [31:0] i_rs2_data,
    output logic [4:0]  o_rs1_addr,
    output logic [4:0]  o_rs2_addr,
    output issue_t      o_issue
);

    logic [6:0]  w_opcode;
    logic [6:0]  w_funct7;
    logic [2:0]  w_funct3;
    logic [31:0] w_imm_i;
    logic [31:0] w_imm_u;
    logic [31:0] w_shamt;
    logic        w_legal;
    issue_t      w_raw;

    assign w_opcode   = i_instr[6:0];
    assign w_funct3   = i_instr[14:12];
    assign w_funct7   = i_instr[31:25];
    assign w_imm_i    = {{20{i_instr[31]}}, i_instr[31:20]};
    assign w_imm_u    = {i_instr[31:12], 12'b0};
    assign w_shamt    = {27'b0, i_instr[24:20]};
    assign o_rs1_addr = i_instr[19:15];
    assign o_rs2_addr = i_instr[24:20];

    always_comb begin
        w_raw    = '0;
        w_raw.rd = i_instr[11:7];
        w_legal  = 1'b0;
        case (w_opcode)
            `OPC_OP: begin
                w_raw.a = i_rs1_data;
                w_raw.b = i_rs2_data;
                if (w_funct7 == `F7_BASE) begin
                    w_legal      = 1'b1;
                    w_raw.alu_op = f3_to_op(w_funct3);
                end else if (w_funct7 == `F7_ALT && w_funct3 == `F3_ADD_SUB) begin
                    w_legal      = 1'b1;
                    w_raw.alu_op = ALU_SUB;
                end else if (w_funct7 == `F7_ALT && w_funct3 == `F3_SRL_SRA) begin
                    w_legal      = 1'b1;
                    w_raw.alu_op = ALU_SRA;
                end
            end
            `OPC_OP_IMM: begin
                w_raw.a      = i_rs1_data;
                w_raw.b      = w_imm_i;
                w_raw.alu_op = f3_to_op(w_funct3);
                w_legal      = 1'b1;
                // Shift-immediates reuse imm[11:5] as funct7.
                if (w_funct3 == `F3_SLL || w_funct3 == `F3_SRL_SRA) begin
                    w_raw.b = w_shamt;
                    if (w_funct7 == `F7_ALT && w_funct3 == `F3_SRL_SRA) begin
                        w_raw.alu_op = ALU_SRA;
                    end else if (w_funct7 != `F7_BASE) begin
                        w_legal = 1'b0;
                    end
                end
            end
            `OPC_LUI: begin
                w_raw.alu_op = ALU_ADD;
                w_raw.b      = w_imm_u;
                w_legal      = 1'b1;
            end
            `OPC_AUIPC: begin
                w_raw.alu_op = ALU_ADD;
                w_raw.a      = i_pc;
                w_raw.b      = w_imm_u;
                w_legal      = 1'b1;
            end
            default: begin
            end
        endcase
        w_raw.rd_we   = w_legal && (w_raw.rd != 5'd0);
        w_raw.illegal = !w_legal;
    end

`ifdef DECODE_ILLEGAL_TRAP_EN
    always_comb begin
        o_issue = w_raw;
        if (!w_legal) begin
            o_issue.alu_op = ALU_ADD;
            o_issue.a      = '0;
            o_issue.b      = '0;
        end
    end
`else
    assign o_issue = w_raw;
`endif

endmodule

// File: rtl/alu_issue_stage.sv
// ALU issue stage: decode plus an output register backed by one skid register (2 entries).
// DECODE_ILLEGAL_TRAP_EN selects issuing illegal instructions as traps instead of dropping them.
module alu_issue_stage
    import alu_issue_stage_pkg::*;
(
    input logic          clk,
    input logic          rst,
    input logic          flush,
    alu_issue_stage_if.slave bus
);

    issue_t     w_dec;
    issue_t     w_entry;
    logic       w_keep;
    logic       w_in_fire;
    logic       w_out_fire;
    logic [4:0] w_rs1_addr;
    logic [4:0] w_rs2_addr;

    issue_t r_out;
    issue_t r_skid;
    logic   r_out_valid;
    logic   r_skid_valid;
    issue_t w_out_d;
    issue_t w_skid_d;
    logic   w_out_valid_d;
    logic   w_skid_valid_d;

    rv32i_alu_decode u_decode (
        .i_instr    (bus.in_instr),
        .i_pc       (bus.in_pc),
        .i_rs1_data (bus.rs1_data),
        .i_rs2_data (bus.rs2_data),
        .o_rs1_addr (w_rs1_addr),
        .o_rs2_addr (w_rs2_addr),
        .o_issue    (w_dec)
    );

`ifdef DECODE_ILLEGAL_TRAP_EN
    assign w_entry = w_dec;
    assign w_keep  = 1'b1;
`else
    // Illegal entries are consumed upstream but never occupy a slot.
    always_comb begin
        w_entry         = w_dec;
        w_entry.illegal = 1'b0;
    end
    assign w_keep = !w_dec.illegal;
`endif

    assign w_in_fire  = bus.in_valid && !r_skid_valid;
    assign w_out_fire = r_out_valid && bus.out_ready;

    always_comb begin
        w_out_d        = r_out;
        w_skid_d       = r_skid;
        w_out_valid_d  = r_out_valid;
        w_skid_valid_d = r_skid_valid;
        if (flush) begin
            w_out_valid_d  = 1'b0;
            w_skid_valid_d = 1'b0;
        end else if (!r_out_valid || w_out_fire) begin
            // Skid holds the older entry; while it is full nothing is accepted.
            if (r_skid_valid) begin
                w_out_d        = r_skid;
                w_out_valid_d  = 1'b1;
                w_skid_valid_d = 1'b0;
            end else if (w_in_fire && w_keep) begin
                w_out_d       = w_entry;
                w_out_valid_d = 1'b1;
            end else begin
                w_out_valid_d = 1'b0;
            end
        end else if (w_in_fire && w_keep) begin
            w_skid_d       = w_entry;
            w_skid_valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_out        <= '0;
            r_skid       <= '0;
            r_out_valid  <= 1'b0;
            r_skid_valid <= 1'b0;
        end else begin
            r_out        <= w_out_d;
            r_skid       <= w_skid_d;
            r_out_valid  <= w_out_valid_d;
            r_skid_valid <= w_skid_valid_d;
        end
    end

    assign bus.in_ready    = !r_skid_valid;
    assign bus.rs1_addr    = w_rs1_addr;
    assign bus.rs2_addr    = w_rs2_addr;
    assign bus.out_valid   = r_out_valid;
    assign bus.out_alu_op  = r_out.alu_op;
    assign bus.out_a       = r_out.a;
    assign bus.out_b       = r_out.b;
    assign bus.out_rd      = r_out.rd;
    assign bus.out_rd_we   = r_out.rd_we;
    assign bus.out_illegal = r_out.illegal;

endmodule
